ece751_axil_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register bank that replaces the fixed four-register control slave in front of the ece751_h264_enc core.
- Writable control registers drive encoder configuration. Status registers are sampled from encoder outputs. Each write also raises a per-register pulse.

---
 rtl/ece751_axil_pkg.sv | 44 ++++
 rtl/ece751_axil_regfile_wr_join.sv | 112 +++++++++++
 rtl/ece751_axil_regfile.sv | 204 ++++++++++++++++++++
 tb/tb_ece751_axil_regfile.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ece751_axil_pkg.sv
// ---------------------------------------------------------------------------
// ece751_axil_pkg
// Shared types and helpers for the ece751 AXI4-Lite register bank.
//   resp_t      : AXI response codes (OKAY / SLVERR)
//   wr_state_t  : write-channel join FSM states
//   addr_to_idx : byte address -> register index
//   in_range    : byte address lies inside the register window
// Indices are carried as IDX_W bits so that NUM_REGS = 1 (zero index bits)
// never produces a zero-width signal.
// ---------------------------------------------------------------------------
package ece751_axil_pkg;

   localparam int IDX_W = 6;   // enough for up to 64 registers

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HAVE_AW = 2'b01,
      HAVE_W  = 2'b10,
      RESP    = 2'b11
   } wr_state_t;

   // Drops the byte-lane bits, then keeps idx_bits bits of word index.
   function automatic logic [IDX_W-1:0] addr_to_idx(input logic [63:0] addr,
                                                    input int addr_lsb,
                                                    input int idx_bits);
      logic [63:0] shifted;
      logic [63:0] mask;
      shifted = addr >> addr_lsb;
      mask    = (64'd1 << idx_bits) - 64'd1;
      return IDX_W'(shifted & mask);
   endfunction

   function automatic logic in_range(input logic [63:0] addr,
                                     input int num_regs,
                                     input int bytes_per_reg);
      return addr < 64'(num_regs * bytes_per_reg);
   endfunction

endpackage

// File: rtl/ece751_axil_regfile_wr_join.sv
// ---------------------------------------------------------------------------
// ece751_axil_wr_join
// Joins the AXI4-Lite AW and W channels (either order or same cycle) and
// holds the B response until BREADY.
//   clk, srst          : clock, synchronous active-high reset
//   ready_en_i         : 0 keeps AWREADY/WREADY low (first cycle out of reset)
//   awaddr_i/awvalid_i/awready_o : write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o : write data channel
//   bready_i/bvalid_o  : write response handshake
//   commit_o           : one-cycle strobe, high on the edge completing AW+W
//   commit_idx_o, commit_in_range_o, commit_data_o, commit_strb_o :
//                        register index, window check, data and strobes
//                        for the committing write (valid with commit_o)
// ---------------------------------------------------------------------------
module ece751_axil_wr_join
   import ece751_axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    ready_en_i,
   input  logic [ADDR_WIDTH-1:0]   awaddr_i,
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic                    bready_i,
   output logic                    bvalid_o,
   output logic                    commit_o,
   output logic [IDX_W-1:0]        commit_idx_o,
   output logic                    commit_in_range_o,
   output logic [DATA_WIDTH-1:0]   commit_data_o,
   output logic [DATA_WIDTH/8-1:0] commit_strb_o
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_BITS = $clog2(NUM_REGS);

   wr_state_t               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [STRB_W-1:0]       strb_q, strb_d;

   logic                    aw_hs;
   logic                    w_hs;
   logic [ADDR_WIDTH-1:0]   sel_addr;

   // State register
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
      end
   end

   // Next-state logic; a buffered half is kept until its partner arrives.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      strb_d  = strb_q;
      case (state_q)
         IDLE: begin
            if (aw_hs && w_hs) begin
               state_d = RESP;
            end else if (aw_hs) begin
               state_d = HAVE_AW;
               addr_d  = awaddr_i;
            end else if (w_hs) begin
               state_d = HAVE_W;
               data_d  = wdata_i;
               strb_d  = wstrb_i;
            end
         end
         HAVE_AW: if (w_hs)     state_d = RESP;
         HAVE_W:  if (aw_hs)    state_d = RESP;
         RESP:    if (bready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: readiness, handshakes and the commit bundle.
   always_comb begin
      awready_o = ready_en_i && (state_q == IDLE || state_q == HAVE_W);
      wready_o  = ready_en_i && (state_q == IDLE || state_q == HAVE_AW);
      bvalid_o  = (state_q == RESP);
      aw_hs     = awvalid_i && awready_o;
      w_hs      = wvalid_i && wready_o;
      commit_o  = (state_q == IDLE    && aw_hs && w_hs) ||
                  (state_q == HAVE_AW && w_hs) ||
                  (state_q == HAVE_W  && aw_hs);
      sel_addr          = (state_q == HAVE_AW) ? addr_q : awaddr_i;
      commit_data_o     = (state_q == HAVE_W)  ? data_q : wdata_i;
      commit_strb_o     = (state_q == HAVE_W)  ? strb_q : wstrb_i;
      commit_idx_o      = addr_to_idx(64'(sel_addr), ADDR_LSB, IDX_BITS);
      commit_in_range_o = in_range(64'(sel_addr), NUM_REGS, STRB_W);
   end

endmodule

// File: rtl/ece751_axil_regfile.sv
// ---------------------------------------------------------------------------
// ece751_axil_regfile
// AXI4-Lite slave register bank for the ece751_h264_enc core.
// Writable registers drive ctrl_o; read-only registers (RO_MASK bit set)
// return the matching status_i slice. Every committed write to a writable
// register pulses wr_pulse_o[idx] for one cycle.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET : clock, synchronous active-high reset
//   S_AXI_AW* / W* / B*      : AXI4-Lite write channels
//   S_AXI_AR* / R*           : AXI4-Lite read channels
//   ctrl_o     : NUM_REGS x DATA_WIDTH register contents (RO slices = 0)
//   status_i   : NUM_REGS x DATA_WIDTH status inputs (RO slices used)
//   wr_pulse_o : per-register write pulse
// Build option: define ECE751_AXIL_SLVERR_EN to answer out-of-range
// accesses and writes to RO registers with SLVERR; otherwise always OKAY.
// ---------------------------------------------------------------------------
module ece751_axil_regfile
   import ece751_axil_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          NUM_REGS   = 8,
   parameter int          ADDR_WIDTH = 8,
   parameter logic [63:0] RO_MASK    = 64'hF0
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_BITS = $clog2(NUM_REGS);

   logic clk;
   logic srst;
   assign clk  = S_AXI_ACLK;
   assign srst = S_AXI_ARESET;

   // Holds all READY outputs low until the first edge after reset releases.
   logic ready_en_q, ready_en_d;
   assign ready_en_d = 1'b1;

   // ---------------- write path ----------------
   logic                    commit;
   logic [IDX_W-1:0]        commit_idx;
   logic                    commit_in_range;
   logic [DATA_WIDTH-1:0]   commit_data;
   logic [STRB_W-1:0]       commit_strb;
   logic                    wr_ok;
   resp_t                   bresp_q, bresp_d;
   logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;

   // Flattened read sources: register value or status slice per index.
   logic [NUM_REGS*DATA_WIDTH-1:0] rd_src;

   ece751_axil_wr_join #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_wr_join (
      .clk               (clk),
      .srst              (srst),
      .ready_en_i        (ready_en_q),
      .awaddr_i          (S_AXI_AWADDR),
      .awvalid_i         (S_AXI_AWVALID),
      .awready_o         (S_AXI_AWREADY),
      .wdata_i           (S_AXI_WDATA),
      .wstrb_i           (S_AXI_WSTRB),
      .wvalid_i          (S_AXI_WVALID),
      .wready_o          (S_AXI_WREADY),
      .bready_i          (S_AXI_BREADY),
      .bvalid_o          (S_AXI_BVALID),
      .commit_o          (commit),
      .commit_idx_o      (commit_idx),
      .commit_in_range_o (commit_in_range),
      .commit_data_o     (commit_data),
      .commit_strb_o     (commit_strb)
   );

   // A write lands only on an in-range, writable register.
   assign wr_ok = commit_in_range && !RO_MASK[commit_idx];

   always_comb begin
      bresp_d = bresp_q;
      if (commit) begin
`ifdef ECE751_AXIL_SLVERR_EN
         bresp_d = wr_ok ? OKAY : SLVERR;
`else
         bresp_d = OKAY;
`endif
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
         assign ctrl_o[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
         assign rd_src[gi*DATA_WIDTH +: DATA_WIDTH] = status_i[gi*DATA_WIDTH +: DATA_WIDTH];
         assign wr_pulse_d[gi]                      = 1'b0;
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] reg_q, reg_d;
         logic                  hit;

         // The pulse fires on any committed write, even with WSTRB = 0.
         always_comb begin
            hit   = commit && wr_ok && (commit_idx == IDX_W'(gi));
            reg_d = reg_q;
            for (int b = 0; b < STRB_W; b++) begin
               if (hit && commit_strb[b]) begin
                  reg_d[b*8 +: 8] = commit_data[b*8 +: 8];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (srst) reg_q <= '0;
            else      reg_q <= reg_d;
         end

         assign ctrl_o[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
         assign rd_src[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
         assign wr_pulse_d[gi]                      = hit;
      end
   end

   // Status of writable slices is not consumed.
   logic unused_status;
   assign unused_status = ^status_i;

   // ---------------- read path ----------------
   logic                  ar_hs;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_in_range;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   resp_t                 rresp_q, rresp_d;
   logic                  rvalid_q, rvalid_d;

   assign S_AXI_ARREADY = ready_en_q && !rvalid_q;
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
   assign rd_idx        = addr_to_idx(64'(S_AXI_ARADDR), ADDR_LSB, IDX_BITS);
   assign rd_in_range   = in_range(64'(S_AXI_ARADDR), NUM_REGS, STRB_W);

   // Register values sampled here are pre-write when a write commits on
   // the same edge.
   always_comb begin
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rvalid_d = rvalid_q;
      if (ar_hs) begin
         rdata_d  = rd_in_range ? rd_src[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
`ifdef ECE751_AXIL_SLVERR_EN
         rresp_d  = rd_in_range ? OKAY : SLVERR;
`else
         rresp_d  = OKAY;
`endif
         rvalid_d = 1'b1;
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         ready_en_q <= 1'b0;
         bresp_q    <= OKAY;
         wr_pulse_q <= '0;
         rdata_q    <= '0;
         rresp_q    <= OKAY;
         rvalid_q   <= 1'b0;
      end else begin
         ready_en_q <= ready_en_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign wr_pulse_o   = wr_pulse_q;

endmodule

// File: tb/tb_ece751_axil_regfile.sv
// ---------------------------------------------------------------------------
// tb_ece751_axil_regfile
// Directed bench for ece751_axil_regfile (DATA_WIDTH=32, NUM_REGS=8,
// RO_MASK=F0). Inputs change and outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_ece751_axil_regfile;

`ifdef ECE751_AXIL_SLVERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [7:0]   araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [255:0] ctrl;
   logic [255:0] status;
   logic [7:0]   wr_pulse;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt [8];

   always #5 clk = ~clk;

   ece751_axil_regfile #(
      .DATA_WIDTH (32),
      .NUM_REGS   (8),
      .ADDR_WIDTH (8),
      .RO_MASK    (64'hF0)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .ctrl_o        (ctrl),
      .status_i      (status),
      .wr_pulse_o    (wr_pulse)
   );

   initial for (int i = 0; i < 8; i++) pulse_cnt[i] = 0;

   always @(negedge clk) begin
      for (int i = 0; i < 8; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      bit aw_done, w_done, aw_now, w_now;
      int t;
      aw_done = 0; w_done = 0; t = 0;
      awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
      while (!(aw_done && w_done) && t < 20) begin
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         cyc();
         t++;
         if (aw_now) begin aw_done = 1; awvalid = 0; end
         if (w_now)  begin w_done  = 1; wvalid  = 0; end
      end
      awvalid = 0; wvalid = 0;
      n_cmp++;
      if (!(aw_done && w_done)) begin
         n_err++;
         $display("FAIL wr_handshake addr=%h: accepted aw=%0d w=%0d, required both", a, aw_done, w_done);
      end
      t = 0;
      while (!bvalid && t < 20) begin cyc(); t++; end
      n_cmp++;
      if (bvalid !== 1'b1) begin
         n_err++;
         $display("FAIL wr_bvalid_timeout addr=%h: bvalid=%b, required 1", a, bvalid);
      end
      resp = bresp;
      bready = 1;
      cyc();
      bready = 0;
      $display("write addr=%h data=%h strb=%b bresp=%b", a, d, s, resp);
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
      int t;
      t = 0;
      araddr = a; arvalid = 1;
      while (!arready && t < 20) begin cyc(); t++; end
      cyc();
      arvalid = 0;
      n_cmp++;
      if (rvalid !== 1'b1) begin
         n_err++;
         $display("FAIL rd_rvalid addr=%h: rvalid=%b, required 1 one edge after AR", a, rvalid);
      end
      d = rdata; resp = rresp;
      rready = 1;
      cyc();
      rready = 0;
      $display("read  addr=%h rdata=%h rresp=%b", a, d, resp);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) cyc();
      n_cmp++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_handshake: aw/w/ar ready,bvalid,rvalid=%b, required 00000",
                  {awready, wready, arready, bvalid, rvalid});
      end
      n_cmp++;
      if (ctrl !== 256'h0 || wr_pulse !== 8'h0) begin
         n_err++;
         $display("FAIL reset_ctrl: ctrl=%h pulse=%h, required 0", ctrl, wr_pulse);
      end
      n_cmp++;
      if (rdata !== 32'h0 || bresp !== 2'b0 || rresp !== 2'b0) begin
         n_err++;
         $display("FAIL reset_resp: rdata=%h bresp=%b rresp=%b, required 0", rdata, bresp, rresp);
      end
      rst = 0;
      cyc();
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_err++;
         $display("FAIL reset_release_ready: aw/w/ar ready=%b, required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_basic();
      logic [1:0]  r;
      logic [31:0] d;
      int p0 [8];
      p0 = pulse_cnt;
      for (int i = 0; i < 4; i++) begin
         axi_write(8'(i * 4), 32'(i + 1), 4'hF, r);
         n_cmp++;
         if (r !== 2'b00) begin
            n_err++;
            $display("FAIL basic_bresp[%0d]: got %b, required 00", i, r);
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(8'(i * 4), d, r);
         n_cmp++;
         if (d !== 32'(i + 1) || r !== 2'b00) begin
            n_err++;
            $display("FAIL basic_read[%0d]: got %h/%b, required %h/00", i, d, r, 32'(i + 1));
         end
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (pulse_cnt[i] - p0[i] != ((i < 4) ? 1 : 0)) begin
            n_err++;
            $display("FAIL basic_pulse[%0d]: count %0d, required %0d", i, pulse_cnt[i] - p0[i], (i < 4) ? 1 : 0);
         end
      end
   endtask

   task automatic test_w_before_aw();
      logic [1:0]  r;
      logic [31:0] d;
      axi_write(8'h00, 32'h11111111, 4'hF, r);
      wdata = 32'hDEADBEEF; wstrb = 4'b0011; wvalid = 1;
      cyc();
      wvalid = 0;
      n_cmp++;
      if ({awready, wready, bvalid} !== 3'b100) begin
         n_err++;
         $display("FAIL wfirst_have_w: awready,wready,bvalid=%b, required 100", {awready, wready, bvalid});
      end
      cyc();
      cyc();
      awaddr = 8'h00; awvalid = 1;
      cyc();
      awvalid = 0;
      n_cmp++;
      if (bvalid !== 1'b1 || wr_pulse !== 8'h01) begin
         n_err++;
         $display("FAIL wfirst_commit: bvalid=%b pulse=%h, required 1/01", bvalid, wr_pulse);
      end
      n_cmp++;
      if (ctrl[31:0] !== 32'h1111BEEF) begin
         n_err++;
         $display("FAIL wfirst_ctrl0: got %h, required 1111BEEF", ctrl[31:0]);
      end
      bready = 1;
      cyc();
      bready = 0;
      n_cmp++;
      if (bvalid !== 1'b0 || wr_pulse !== 8'h00) begin
         n_err++;
         $display("FAIL wfirst_release: bvalid=%b pulse=%h, required 0/00", bvalid, wr_pulse);
      end
      $display("write addr=00 data=deadbeef strb=0011 (W first) done");
      axi_read(8'h00, d, r);
      n_cmp++;
      if (d !== 32'h1111BEEF) begin
         n_err++;
         $display("FAIL wfirst_readback: got %h, required 1111BEEF", d);
      end
   endtask

   task automatic test_aw_first_wstrb_zero();
      logic [1:0]  r;
      logic [31:0] d;
      awaddr = 8'h08; awvalid = 1;
      cyc();
      awvalid = 0;
      n_cmp++;
      if ({awready, wready} !== 2'b01) begin
         n_err++;
         $display("FAIL awfirst_have_aw: awready,wready=%b, required 01", {awready, wready});
      end
      cyc();
      wdata = 32'hFFFFFFFF; wstrb = 4'b0000; wvalid = 1;
      cyc();
      wvalid = 0;
      n_cmp++;
      if (bvalid !== 1'b1 || wr_pulse !== 8'h04 || bresp !== 2'b00) begin
         n_err++;
         $display("FAIL strb0_commit: bvalid=%b pulse=%h bresp=%b, required 1/04/00", bvalid, wr_pulse, bresp);
      end
      bready = 1;
      cyc();
      bready = 0;
      $display("write addr=08 data=ffffffff strb=0000 (AW first) done");
      axi_read(8'h08, d, r);
      n_cmp++;
      if (d !== 32'h3) begin
         n_err++;
         $display("FAIL strb0_unchanged: got %h, required 00000003", d);
      end
   endtask

   task automatic test_ro_status();
      logic [1:0]  r;
      logic [31:0] d;
      int p0 [8];
      status[4*32 +: 32] = 32'hCAFEF00D;
      p0 = pulse_cnt;
      axi_write(8'h10, 32'h0, 4'hF, r);
      n_cmp++;
      if (r !== ERR_RESP) begin
         n_err++;
         $display("FAIL ro_bresp: got %b, required %b", r, ERR_RESP);
      end
      axi_read(8'h10, d, r);
      n_cmp++;
      if (d !== 32'hCAFEF00D || r !== 2'b00) begin
         n_err++;
         $display("FAIL ro_read: got %h/%b, required CAFEF00D/00", d, r);
      end
      n_cmp++;
      if (pulse_cnt[4] != p0[4] || ctrl[159:128] !== 32'h0) begin
         n_err++;
         $display("FAIL ro_no_pulse: pulses %0d ctrl4=%h, required 0/0", pulse_cnt[4] - p0[4], ctrl[159:128]);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0]  r;
      logic [31:0] d;
      axi_read(8'h20, d, r);
      n_cmp++;
      if (d !== 32'h0 || r !== ERR_RESP) begin
         n_err++;
         $display("FAIL oor_read: got %h/%b, required 00000000/%b", d, r, ERR_RESP);
      end
      axi_write(8'h20, 32'h12345678, 4'hF, r);
      n_cmp++;
      if (r !== ERR_RESP) begin
         n_err++;
         $display("FAIL oor_bresp: got %b, required %b", r, ERR_RESP);
      end
      n_cmp++;
      if (ctrl[127:0] !== {32'h4, 32'h3, 32'h2, 32'h1111BEEF} || ctrl[255:128] !== 128'h0) begin
         n_err++;
         $display("FAIL oor_no_write: ctrl=%h, required unchanged", ctrl);
      end
      axi_read(8'h07, d, r);
      n_cmp++;
      if (d !== 32'h2) begin
         n_err++;
         $display("FAIL low_bits_ignored: got %h, required 00000002", d);
      end
   endtask

   task automatic test_same_edge();
      logic [1:0]  r;
      logic [31:0] d;
      awaddr = 8'h04; awvalid = 1; wdata = 32'h9; wstrb = 4'hF; wvalid = 1;
      araddr = 8'h04; arvalid = 1;
      cyc();
      awvalid = 0; wvalid = 0; arvalid = 0;
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== 32'h2) begin
         n_err++;
         $display("FAIL same_edge_rdata: rvalid=%b rdata=%h, required 1/00000002", rvalid, rdata);
      end
      n_cmp++;
      if (bvalid !== 1'b1 || ctrl[63:32] !== 32'h9) begin
         n_err++;
         $display("FAIL same_edge_write: bvalid=%b ctrl1=%h, required 1/00000009", bvalid, ctrl[63:32]);
      end
      bready = 1; rready = 1;
      cyc();
      bready = 0; rready = 0;
      $display("write+read addr=04 same edge done");
      axi_read(8'h04, d, r);
      n_cmp++;
      if (d !== 32'h9) begin
         n_err++;
         $display("FAIL same_edge_after: got %h, required 00000009", d);
      end
   endtask

   task automatic test_bready_hold_reset();
      awaddr = 8'h0C; awvalid = 1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
      cyc();
      awvalid = 0; wvalid = 0;
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({bvalid, awready, wready} !== 3'b100) begin
            n_err++;
            $display("FAIL hold_cycle%0d: bvalid,awready,wready=%b, required 100", k, {bvalid, awready, wready});
         end
         cyc();
      end
      $display("write addr=0c data=00000055 held without bready");
      rst = 1;
      cyc();
      n_cmp++;
      if (bvalid !== 1'b0 || ctrl !== 256'h0) begin
         n_err++;
         $display("FAIL hold_reset: bvalid=%b ctrl=%h, required 0/0", bvalid, ctrl);
      end
      rst = 0;
      cyc();
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_err++;
         $display("FAIL hold_reset_release: ready=%b, required 111", {awready, wready, arready});
      end
   endtask

   initial begin
      rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 0; araddr = 0; arvalid = 0; rready = 0; status = '0;
      test_reset();
      test_basic();
      test_w_before_aw();
      test_aw_first_wstrb_zero();
      test_ro_status();
      test_out_of_range();
      test_same_edge();
      test_bready_hold_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
